// File: rtl/audio_frame_scheduler.sv
// ---------------------------------------------------------------------------
// audio_frame_scheduler
//
// Master timing and sample-flow controller for the audio path. Derives the
// serial bit clock, word select and bit index from input_clk, owns a
// one-entry sample buffer fed from the SPI/DSP side, and once per stereo
// frame hands one mono sample to the I2S transmitter. Also handles
// start/stop sequencing, priming, underrun detection and recovery.
//
// Ports
//   input_clk      in   system clock (12.288 MHz nominal)
//   reset          in   synchronous, active-low
//   enable         in   level: 1 = stream audio
//   in_valid       in   upstream sample valid
//   in_sample      in   upstream sample (signed PCM)
//   in_ready       out  buffer can accept; transfer on in_valid && in_ready
//   serial_clk     out  bit clock (input_clk / CLK_DIV)
//   ws             out  word select: 0 = left slot, 1 = right slot
//   bit_idx        out  bit position within the current slot
//   tx_load        out  1-cycle strobe: tx_sample valid for the new frame
//   tx_sample      out  sample for the transmitter, held between loads
//   underrun       out  1-cycle pulse: RUN frame boundary with empty buffer
//   underrun_count out  saturating underrun count (cleared only by reset)
//   running        out  1 while in PRIME, RUN or STOP
// ---------------------------------------------------------------------------
module audio_frame_scheduler #(
  parameter int CLK_DIV        = 4,
  parameter int BITS_PER_SLOT  = 32,
  parameter int SAMPLE_W       = 16,
  parameter int UNDERRUN_MODE  = 0,
  parameter int UNDERRUN_LIMIT = 8
) (
  input  logic                input_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                in_ready,
  output logic                serial_clk,
  output logic                ws,
  output logic [4:0]          bit_idx,
  output logic                tx_load,
  output logic [SAMPLE_W-1:0] tx_sample,
  output logic                underrun,
  output logic [7:0]          underrun_count,
  output logic                running
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CON_W = $clog2(UNDERRUN_LIMIT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [4:0]       BIT_LAST = 5'(BITS_PER_SLOT - 1);
  localparam logic [CON_W-1:0] CON_LAST = CON_W'(UNDERRUN_LIMIT - 1);
  localparam logic [CON_W-1:0] CON_ONE  = CON_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                serial_clk_q, serial_clk_d;
  logic                ws_q, ws_d;
  logic [4:0]          bit_idx_q, bit_idx_d;
  logic                buf_full_q, buf_full_d;
  logic [SAMPLE_W-1:0] buf_data_q, buf_data_d;
  logic                tx_load_q, tx_load_d;
  logic [SAMPLE_W-1:0] tx_sample_q, tx_sample_d;
  logic                underrun_q, underrun_d;
  logic [7:0]          underrun_count_q, underrun_count_d;
  logic [CON_W-1:0]    consec_q, consec_d;

  logic div_wrap;
  logic bit_last;
  logic fb;
  logic xfer;

  assign in_ready = !buf_full_q && ((state_q == S_PRIME) || (state_q == S_RUN));
  assign running  = (state_q != S_IDLE);

  assign div_wrap = (div_cnt_q == DIV_LAST);
  assign bit_last = (bit_idx_q == BIT_LAST);
  // Last input_clk cycle of the right slot: all frame decisions happen here,
  // using the buffer state registered before this cycle.
  assign fb       = running && div_wrap && bit_last && ws_q;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d          = state_q;
    div_cnt_d        = div_cnt_q;
    serial_clk_d     = serial_clk_q;
    ws_d             = ws_q;
    bit_idx_d        = bit_idx_q;
    buf_full_d       = buf_full_q;
    buf_data_d       = buf_data_q;
    tx_load_d        = 1'b0;
    tx_sample_d      = tx_sample_q;
    underrun_d       = 1'b0;
    underrun_count_d = underrun_count_q;
    consec_d         = consec_q;

    // Clock generation runs in every active state, including STOP.
    if (state_q != S_IDLE) begin
      if (div_wrap) begin
        div_cnt_d = '0;
        if (bit_last) begin
          bit_idx_d = '0;
          ws_d      = ~ws_q;
        end else begin
          bit_idx_d = bit_idx_q + 5'd1;
        end
      end else begin
        div_cnt_d = div_cnt_q + DIV_ONE;
      end
      // Registered from the next divider value so serial_clk lines up
      // with div_cnt; its falling edge coincides with the bit_idx step.
      serial_clk_d = (div_cnt_d >= DIV_HALF);
    end

    // A transfer can never coincide with a consumption: in_ready requires
    // an empty buffer, and consumption requires a full one.
    if (xfer) begin
      buf_full_d = 1'b1;
      buf_data_d = in_sample;
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_PRIME;
        end
      end

      S_PRIME: begin
        if (fb) begin
          tx_load_d = 1'b1;
          if (buf_full_q) begin
            tx_sample_d = buf_data_q;
            buf_full_d  = 1'b0;
            consec_d    = '0;
            state_d     = S_RUN;
          end else begin
            tx_sample_d = '0;
          end
        end
        if (!enable) begin
          state_d = S_STOP;
        end
      end

      S_RUN: begin
        if (fb) begin
          tx_load_d = 1'b1;
          if (buf_full_q) begin
            tx_sample_d = buf_data_q;
            buf_full_d  = 1'b0;
            consec_d    = '0;
          end else begin
            underrun_d = 1'b1;
            if (underrun_count_q != 8'hFF) begin
              underrun_count_d = underrun_count_q + 8'd1;
            end
            // Mode 1 repeats the sample already presented to the transmitter.
            tx_sample_d = (UNDERRUN_MODE != 0) ? tx_sample_q : '0;
            if (consec_q == CON_LAST) begin
              consec_d = '0;
              state_d  = S_PRIME;
            end else begin
              consec_d = consec_q + CON_ONE;
            end
          end
        end
        if (!enable) begin
          state_d = S_STOP;
        end
      end

      S_STOP: begin
        // Drain to the frame boundary without loading; enable is ignored.
        if (fb) begin
          buf_full_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Entering or sitting in IDLE: clocks, buffer and transmit outputs are
    // all forced quiet so the first IDLE cycle already shows zeros.
    if (state_d == S_IDLE) begin
      div_cnt_d    = '0;
      serial_clk_d = 1'b0;
      ws_d         = 1'b0;
      bit_idx_d    = '0;
      buf_full_d   = 1'b0;
      buf_data_d   = '0;
      tx_load_d    = 1'b0;
      tx_sample_d  = '0;
      underrun_d   = 1'b0;
      consec_d     = '0;
    end
  end

  always_ff @(posedge input_clk) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      div_cnt_q        <= '0;
      serial_clk_q     <= 1'b0;
      ws_q             <= 1'b0;
      bit_idx_q        <= '0;
      buf_full_q       <= 1'b0;
      buf_data_q       <= '0;
      tx_load_q        <= 1'b0;
      tx_sample_q      <= '0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
      consec_q         <= '0;
    end else begin
      state_q          <= state_d;
      div_cnt_q        <= div_cnt_d;
      serial_clk_q     <= serial_clk_d;
      ws_q             <= ws_d;
      bit_idx_q        <= bit_idx_d;
      buf_full_q       <= buf_full_d;
      buf_data_q       <= buf_data_d;
      tx_load_q        <= tx_load_d;
      tx_sample_q      <= tx_sample_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
      consec_q         <= consec_d;
    end
  end

  assign serial_clk     = serial_clk_q;
  assign ws             = ws_q;
  assign bit_idx        = bit_idx_q;
  assign tx_load        = tx_load_q;
  assign tx_sample      = tx_sample_q;
  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_audio_frame_scheduler
//
// Directed bench for audio_frame_scheduler (UNDERRUN_MODE = 1). A
// behavioural model derives clock outputs from the elapsed time since
// streaming started and tracks buffer/frame behaviour per frame; a compare
// process checks every DUT output against it on each falling edge. The
// stimulus sequence additionally pins hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_audio_frame_scheduler;

  localparam int CLK_DIV = 4;
  localparam int BPS     = 32;
  localparam int SW      = 16;
  localparam int MODE    = 1;
  localparam int LIMIT   = 8;
  localparam int FRAME   = 2 * BPS * CLK_DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          in_valid;
  logic [SW-1:0] in_sample;
  logic          in_ready;
  logic          serial_clk;
  logic          ws;
  logic [4:0]    bit_idx;
  logic          tx_load;
  logic [SW-1:0] tx_sample;
  logic          underrun;
  logic [7:0]    underrun_count;
  logic          running;

  always #5 clk = ~clk;

  audio_frame_scheduler #(
    .CLK_DIV        (CLK_DIV),
    .BITS_PER_SLOT  (BPS),
    .SAMPLE_W       (SW),
    .UNDERRUN_MODE  (MODE),
    .UNDERRUN_LIMIT (LIMIT)
  ) dut (
    .input_clk      (clk),
    .reset          (rst_n),
    .enable         (enable),
    .in_valid       (in_valid),
    .in_sample      (in_sample),
    .in_ready       (in_ready),
    .serial_clk     (serial_clk),
    .ws             (ws),
    .bit_idx        (bit_idx),
    .tx_load        (tx_load),
    .tx_sample      (tx_sample),
    .underrun       (underrun),
    .underrun_count (underrun_count),
    .running        (running)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit started  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_state: 0 idle, 1 prime, 2 run, 3 stop
  int          m_state  = 0;
  int          m_t      = 0;   // cycles elapsed since streaming started
  bit          m_full   = 1'b0;
  logic [15:0] m_buf    = '0;
  logic [15:0] m_tx     = '0;
  bit          m_load   = 1'b0;
  bit          m_under  = 1'b0;
  int          m_count  = 0;
  int          m_consec = 0;
  bit          m_fb;
  bit          m_xfer;
  int          m_ns;

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (!rst_n) begin
      m_state = 0; m_t = 0; m_full = 0; m_buf = '0; m_tx = '0;
      m_load = 0; m_under = 0; m_count = 0; m_consec = 0;
    end else begin
      m_fb   = (m_state != 0) && ((m_t % FRAME) == FRAME - 1);
      m_xfer = in_valid && !m_full && (m_state == 1 || m_state == 2);
      m_ns   = m_state;
      m_load = 0;
      m_under = 0;
      if (m_state == 0) begin
        if (enable) m_ns = 1;
      end else if (m_state == 3) begin
        if (m_fb) m_ns = 0;
      end else begin
        if (m_fb) begin
          m_load = 1;
          if (m_full) begin
            m_tx = m_buf; m_full = 0; m_consec = 0; m_ns = 2;
          end else if (m_state == 1) begin
            m_tx = '0;
          end else begin
            m_under = 1;
            if (m_count < 255) m_count++;
            if (MODE == 0) m_tx = '0;
            m_consec++;
            if (m_consec == LIMIT) begin m_consec = 0; m_ns = 1; end
          end
        end
        if (!enable) m_ns = 3;
      end
      if (m_xfer) begin m_full = 1; m_buf = in_sample; end
      if (m_ns == 0) begin
        m_t = 0; m_full = 0; m_buf = '0; m_tx = '0;
        m_load = 0; m_under = 0; m_consec = 0;
      end else if (m_state != 0) begin
        m_t++;
      end else begin
        m_t = 0;
      end
      m_state = m_ns;
    end
  end

  // ---------------- compare process ----------------
  int e_sclk, e_ws, e_bit;

  always @(negedge clk) begin
    if (started) begin
      if (m_state == 0) begin
        e_sclk = 0; e_ws = 0; e_bit = 0;
      end else begin
        e_sclk = ((m_t % CLK_DIV) >= CLK_DIV / 2) ? 1 : 0;
        e_bit  = (m_t / CLK_DIV) % BPS;
        e_ws   = (m_t / (CLK_DIV * BPS)) % 2;
      end
      check("cmp_serial_clk", serial_clk, e_sclk);
      check("cmp_ws", ws, e_ws);
      check("cmp_bit_idx", bit_idx, e_bit);
      check("cmp_tx_load", tx_load, m_load);
      check("cmp_tx_sample", tx_sample, m_tx);
      check("cmp_underrun", underrun, m_under);
      check("cmp_underrun_count", underrun_count, m_count);
      check("cmp_running", running, (m_state != 0) ? 1 : 0);
      check("cmp_in_ready", in_ready, (!m_full && (m_state == 1 || m_state == 2)) ? 1 : 0);
    end
  end

  // ---------------- directed stimulus ----------------
  int load_cyc  = 0;
  int prev_load = 0;
  int start_cyc = 0;

  task automatic wait_load(input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_load !== 1'b1 && n < max_cyc);
    check("load_seen", tx_load, 1);
    prev_load = load_cyc;
    load_cyc  = cyc;
    $display("load: cycle %0d sample 0x%04h underrun %0b count %0d",
             cyc, tx_sample, underrun, underrun_count);
  endtask

  task automatic send(input logic [15:0] s);
    in_valid  = 1'b1;
    in_sample = s;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; in_valid = 1'b0; in_sample = '0;
    repeat (5) @(negedge clk);
    check("rst_running", running, 0);
    check("rst_count", underrun_count, 0);
    check("rst_sclk", serial_clk, 0);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    check("idle_sclk", serial_clk, 0);
    check("idle_ready", in_ready, 0);
    check("idle_tx_load", tx_load, 0);

    // Start streaming: PRIME with clocks from t=0
    enable = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    check("t0_sclk", serial_clk, 0);
    check("t0_running", running, 1);
    check("t0_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    check("t2_sclk", serial_clk, 1);
    check("t2_bit", bit_idx, 0);
    repeat (2) @(negedge clk);
    check("t4_sclk", serial_clk, 0);
    check("t4_bit", bit_idx, 1);
    repeat (124) @(negedge clk);
    check("t128_ws", ws, 1);
    check("t128_bit", bit_idx, 0);

    // Three priming frames with no input
    wait_load(300);
    check("prime1_at", load_cyc - start_cyc, FRAME);
    check("prime1_val", tx_sample, 16'h0000);
    check("prime1_ws", ws, 0);
    for (int k = 0; k < 2; k++) begin
      wait_load(300);
      check("prime_interval", load_cyc - prev_load, FRAME);
      check("prime_val", tx_sample, 16'h0000);
      check("prime_no_underrun", underrun, 0);
    end

    // First sample ends priming
    send(16'h1234);
    check("ready_after_xfer", in_ready, 0);
    wait_load(300);
    check("first_interval", load_cyc - prev_load, FRAME);
    check("first_val", tx_sample, 16'h1234);

    // Steady RUN: extra in_valid cycles with other data must not be taken
    for (int i = 1; i <= 4; i++) begin
      in_valid  = 1'b1;
      in_sample = 16'(i);
      @(negedge clk);
      in_sample = 16'(i + 'h100);
      repeat (9) @(negedge clk);
      in_valid = 1'b0;
      wait_load(300);
      check("run_interval", load_cyc - prev_load, FRAME);
      check("run_val", tx_sample, 16'(i));
      check("run_no_underrun", underrun, 0);
    end

    // Underrun with repeat-last mode
    send(16'h7FFF);
    wait_load(300);
    check("pre_ur_val", tx_sample, 16'h7FFF);
    wait_load(300);
    check("ur1_val", tx_sample, 16'h7FFF);
    check("ur1_pulse", underrun, 1);
    check("ur1_count", underrun_count, 1);
    for (int k = 2; k <= LIMIT; k++) begin
      wait_load(300);
      check("ur_val", tx_sample, 16'h7FFF);
      check("ur_pulse", underrun, 1);
    end
    check("ur_count8", underrun_count, 8);
    wait_load(300);
    check("reprime_val", tx_sample, 16'h0000);
    check("reprime_no_ur", underrun, 0);
    check("reprime_count", underrun_count, 8);

    // Back to RUN, then transfer exactly in the frame-boundary cycle
    send(16'h0BEE);
    wait_load(300);
    check("bee_val", tx_sample, 16'h0BEE);
    repeat (255) @(negedge clk);
    check("fb_ws", ws, 1);
    check("fb_bit", bit_idx, 31);
    check("fb_sclk", serial_clk, 1);
    check("fb_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_sample = 16'hAAAA;
    wait_load(2);
    in_valid  = 1'b0;
    check("fbx_underrun", underrun, 1);
    check("fbx_held", tx_sample, 16'h0BEE);
    check("fbx_count", underrun_count, 9);
    wait_load(300);
    check("aaaa_interval", load_cyc - prev_load, FRAME);
    check("aaaa_val", tx_sample, 16'hAAAA);
    check("aaaa_no_ur", underrun, 0);

    // Stop at bit 10 of the left slot
    repeat (41) @(negedge clk);
    check("stop_bit", bit_idx, 10);
    check("stop_ws", ws, 0);
    enable = 1'b0;
    repeat (59) @(negedge clk);
    check("stop_running", running, 1);
    check("stop_ready", in_ready, 0);
    enable    = 1'b1;
    in_valid  = 1'b1;
    in_sample = 16'h5555;
    repeat (155) @(negedge clk);
    check("stopfb_ws", ws, 1);
    check("stopfb_bit", bit_idx, 31);
    check("stopfb_sclk", serial_clk, 1);
    check("stopfb_running", running, 1);
    @(negedge clk);
    check("idle_after_stop", running, 0);
    check("idle_after_stop_sclk", serial_clk, 0);
    check("idle_after_stop_load", tx_load, 0);
    @(negedge clk);
    check("restart_running", running, 1);
    check("restart_bit", bit_idx, 0);
    check("restart_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (100) @(negedge clk);

    // Mid-frame reset discards the buffered 0x5555
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_running", running, 0);
    check("mrst_ready", in_ready, 0);
    check("mrst_count", underrun_count, 0);
    check("mrst_sclk", serial_clk, 0);
    rst_n = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    check("mrst_prime", running, 1);
    wait_load(300);
    check("mrst_load_at", load_cyc - start_cyc, FRAME);
    check("mrst_load_val", tx_sample, 16'h0000);

    enable = 1'b0;
    repeat (300) @(negedge clk);
    check("final_idle", running, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
